// File: rtl/riscv_types.sv
// rtl/riscv_types.sv - shared unit encodings, write-back latencies and reservation entry type
package riscv_types;

    typedef enum logic [3:0] {
        FSQRT_unit    = 4'd0,
        DIV_unit      = 4'd1,
        FDIV_unit     = 4'd2,
        ALU_unit      = 4'd3,
        FPU_unit      = 4'd4,
        MUL_unit      = 4'd5,
        FADD_SUB_unit = 4'd6,
        FMUL_unit     = 4'd7,
        R4_unit       = 4'd8,
        DEFAULT_unit  = 4'd9
    } priority_t;

    localparam int LAT_W         = 4;
    localparam int WB_MAX_LAT    = 8;
    localparam int WB_NUM_MC     = 3;
    localparam int WB_STARVE_LIM = 4;

    // Issue-to-write-back latency per unit; 0 means the unit takes no ring slot at issue.
    localparam logic [LAT_W-1:0] UNIT_LAT [16] = '{
        4'd0, 4'd0, 4'd0,       // FSQRT, DIV, FDIV (multi-cycle, granted later)
        4'd1, 4'd1,             // ALU, FPU
        4'd2,                   // MUL
        4'd3, 4'd3,             // FADD_SUB, FMUL
        4'd4,                   // R4
        4'd0,                   // DEFAULT
        4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0
    };

    typedef struct packed {
        logic      v;
        priority_t unit;
    } wb_res_t;

    localparam wb_res_t WB_RES_EMPTY = '{v: 1'b0, unit: DEFAULT_unit};

    // Multi-cycle requester index to the unit that owns the write port.
    function automatic priority_t mc_unit(input int idx);
        case (idx)
            0:       return FSQRT_unit;
            1:       return DIV_unit;
            default: return FDIV_unit;
        endcase
    endfunction

endpackage

// File: rtl/mc_rr_arbiter.sv
// rtl/mc_rr_arbiter.sv - round-robin one-hot grant among multi-cycle done requests
module mc_rr_arbiter #(
    parameter int NUM_MC = 3,
    localparam int IDX_W = (NUM_MC > 1) ? $clog2(NUM_MC) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_MC-1:0] req_i,
    input  logic              en_i,
    output logic [NUM_MC-1:0] grant_o,
    output logic [IDX_W-1:0]  grant_idx_o
);

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             found;
    int               idx;

    // Scan requests starting at rr_ptr; first hit wins and the pointer moves past it.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        rr_ptr_d    = rr_ptr_q;
        found       = 1'b0;
        idx         = 0;
        for (int off = 0; off < NUM_MC; off++) begin
            idx = int'(rr_ptr_q) + off;
            if (idx >= NUM_MC) idx = idx - NUM_MC;
            if (en_i && !found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = IDX_W'(idx);
                rr_ptr_d     = (idx == NUM_MC - 1) ? '0 : IDX_W'(idx + 1);
            end
        end
    end

    // Pointer register; only moves when a grant is actually made.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rr_ptr_q <= '0;
        else          rr_ptr_q <= rr_ptr_d;
    end

endmodule

// File: rtl/wb_slot_scheduler.sv
// rtl/wb_slot_scheduler.sv - issue-time reservation of the shared EXE/MEM write-back slot
module wb_slot_scheduler
    import riscv_types::*;
#(
    parameter int MAX_LAT    = WB_MAX_LAT,
    parameter int NUM_MC     = WB_NUM_MC,
    parameter int STARVE_LIM = WB_STARVE_LIM
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pipe_stall,
    input  logic              issue_valid,
    input  priority_t         issue_unit,
    output logic              issue_stall,
    input  logic [NUM_MC-1:0] mc_done,
    output logic [NUM_MC-1:0] mc_grant,
    output logic              wb_valid,
    output priority_t         wb_sel
);

    localparam int CNT_W = $clog2(STARVE_LIM + 1);
    localparam int IDX_W = (NUM_MC > 1) ? $clog2(NUM_MC) : 1;

    wb_res_t          res_q   [MAX_LAT];
    wb_res_t          res_d   [MAX_LAT];
    wb_res_t          res_ext [MAX_LAT+1];
    logic [CNT_W-1:0] wait_q, wait_d;
    logic [LAT_W-1:0] lat;
    logic [LAT_W-1:0] wr_idx;
    logic             starve;
    logic             slot_busy;
    logic             issue_acc;
    logic             l1_acc;
    logic             mc_en;
    logic [IDX_W-1:0] win_idx;

    // Ring view with the always-empty slot past the end, so any legal latency indexes it.
    always_comb begin
        for (int i = 0; i < MAX_LAT; i++) res_ext[i] = res_q[i];
        res_ext[MAX_LAT] = WB_RES_EMPTY;
    end

    assign lat       = UNIT_LAT[issue_unit];
    assign wr_idx    = lat - 1'b1;
    assign slot_busy = (lat <= LAT_W'(MAX_LAT)) ? res_ext[lat].v : 1'b1;
    assign starve    = (wait_q == CNT_W'(STARVE_LIM));

    // Accept or refuse the issue against the pre-shift ring; starvation steals latency-1 slots.
    always_comb begin
        issue_stall = 1'b0;
        issue_acc   = 1'b0;
        if (pipe_stall) begin
            issue_stall = issue_valid;
        end else if (issue_valid && lat != '0) begin
            issue_stall = slot_busy | ((lat == LAT_W'(1)) & starve);
            issue_acc   = ~issue_stall;
        end
    end

    assign l1_acc = issue_acc & (lat == LAT_W'(1));
    assign mc_en  = reset_n & ~pipe_stall & ~res_ext[1].v & ~l1_acc;

    mc_rr_arbiter #(.NUM_MC(NUM_MC)) u_arb (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_i       (mc_done),
        .en_i        (mc_en),
        .grant_o     (mc_grant),
        .grant_idx_o (win_idx)
    );

    // Shift the ring toward slot 0, then drop in the new issue and/or multi-cycle grant.
    always_comb begin
        for (int i = 0; i < MAX_LAT; i++) res_d[i] = res_ext[i+1];
        if (issue_acc) res_d[wr_idx] = '{v: 1'b1, unit: issue_unit};
        if (|mc_grant) res_d[0] = '{v: 1'b1, unit: mc_unit(int'(win_idx))};
        if (|mc_grant || mc_done == '0) wait_d = '0;
        else if (!starve)               wait_d = wait_q + 1'b1;
        else                            wait_d = wait_q;
    end

    // Ring and starvation counter; everything freezes while the pipeline is stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MAX_LAT; i++) res_q[i] <= WB_RES_EMPTY;
            wait_q <= '0;
        end else if (!pipe_stall) begin
            for (int i = 0; i < MAX_LAT; i++) res_q[i] <= res_d[i];
            wait_q <= wait_d;
        end
    end

    assign wb_valid = res_q[0].v & ~pipe_stall;
    assign wb_sel   = res_q[0].v ? res_q[0].unit : DEFAULT_unit;

    a_grant_onehot: assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0(mc_grant));
    a_res_free: assert property (@(posedge clk) disable iff (!reset_n)
        issue_acc |-> !res_ext[lat].v);
    a_lat_legal: assert property (@(posedge clk) disable iff (!reset_n)
        issue_valid |-> (lat <= LAT_W'(MAX_LAT)));

endmodule

// File: tb/tb_wb_slot_scheduler.sv
// tb/tb_wb_slot_scheduler.sv - scoreboard bench for wb_slot_scheduler
module tb_wb_slot_scheduler;
    import riscv_types::*;

    logic      clk = 1'b0;
    logic      reset_n = 1'b0;
    logic      pipe_stall = 1'b0;
    logic      issue_valid = 1'b0;
    priority_t issue_unit = DEFAULT_unit;
    logic [2:0] mc_done = 3'b000;
    logic      issue_stall;
    logic [2:0] mc_grant;
    logic      wb_valid;
    priority_t wb_sel;

    wb_slot_scheduler dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pipe_stall  (pipe_stall),
        .issue_valid (issue_valid),
        .issue_unit  (issue_unit),
        .issue_stall (issue_stall),
        .mc_done     (mc_done),
        .mc_grant    (mc_grant),
        .wb_valid    (wb_valid),
        .wb_sel      (wb_sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       stall;
        logic [2:0] grant;
        logic       wbv;
        priority_t  sel;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: absolute write-back schedule keyed by unstalled-cycle number.
    priority_t sched [longint];
    longint    et = 0;
    int        rr = 0;
    int        waitc = 0;
    logic [2:0] pend = 3'b000;

    function automatic int ref_lat(input priority_t u);
        case (u)
            ALU_unit, FPU_unit:       return 1;
            MUL_unit:                 return 2;
            FADD_SUB_unit, FMUL_unit: return 3;
            R4_unit:                  return 4;
            default:                  return 0;
        endcase
    endfunction

    function automatic priority_t mc_name(input int i);
        if (i == 0) return FSQRT_unit;
        if (i == 1) return DIV_unit;
        return FDIV_unit;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: pop one expectation per driven cycle and compare all outputs.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("issue_stall", 32'(issue_stall), 32'(e.stall));
            check("mc_grant",    32'(mc_grant),    32'(e.grant));
            check("wb_valid",    32'(wb_valid),    32'(e.wbv));
            check("wb_sel",      32'(wb_sel),      32'(e.sel));
        end
    end

    task automatic step(input logic v, input priority_t u, input logic st);
        exp_t e;
        int   l;
        bit   starve_m, free1, acc;
        int   win;
        @(posedge clk); #1;
        issue_valid = v;
        issue_unit  = u;
        pipe_stall  = st;
        mc_done     = pend;
        l = ref_lat(u);
        e.sel   = sched.exists(et) ? sched[et] : DEFAULT_unit;
        e.wbv   = sched.exists(et) && !st;
        e.grant = 3'b000;
        e.stall = 1'b0;
        if (st) begin
            e.stall = v;
        end else begin
            starve_m = (waitc == 4);
            free1    = !sched.exists(et + 1);
            acc      = 1'b0;
            if (v && l > 0) begin
                e.stall = sched.exists(et + l) || (l == 1 && starve_m);
                acc = !e.stall;
                if (acc) sched[et + l] = u;
            end
            win = -1;
            if (pend != 3'b000 && free1 && !(acc && l == 1))
                for (int k = 0; k < 3; k++)
                    if (win < 0 && pend[(rr + k) % 3]) win = (rr + k) % 3;
            if (win >= 0) begin
                e.grant[win] = 1'b1;
                sched[et + 1] = mc_name(win);
                rr = (win + 1) % 3;
                waitc = 0;
                pend[win] = 1'b0;
            end else if (pend != 3'b000) begin
                waitc = (waitc < 4) ? waitc + 1 : 4;
            end else begin
                waitc = 0;
            end
            if (sched.exists(et)) sched.delete(et);
            et++;
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, DEFAULT_unit, 1'b0);
    endtask

    task automatic mid_reset();
        @(posedge clk); #1;
        reset_n = 1'b0;
        issue_valid = 1'b0;
        pipe_stall = 1'b0;
        pend = 3'b000;
        mc_done = 3'b000;
        #1;
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_mc_grant", 32'(mc_grant), 32'd0);
        check("rst_wb_sel",   32'(wb_sel),   32'(DEFAULT_unit));
        sched.delete();
        rr = 0;
        waitc = 0;
        @(negedge clk); #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #2;
        check("reset_wb_valid", 32'(wb_valid), 32'd0);
        check("reset_mc_grant", 32'(mc_grant), 32'd0);
        check("reset_wb_sel",   32'(wb_sel),   32'(DEFAULT_unit));
        @(negedge clk); #1;
        reset_n = 1'b1;

        // FMUL latency 3 lands exactly three cycles later
        step(1'b1, FMUL_unit, 1'b0);
        idle(5);

        // MUL then ALU colliding at the same slot; ALU retries
        step(1'b1, MUL_unit, 1'b0);
        step(1'b1, ALU_unit, 1'b0);
        step(1'b1, ALU_unit, 1'b0);
        idle(4);

        // DIV and FDIV round-robin, then pointer back at FSQRT
        pend = 3'b110;
        idle(3);
        pend = 3'b111;
        idle(5);

        // Starvation guard against a continuous ALU stream
        pend = 3'b001;
        repeat (6) step(1'b1, ALU_unit, 1'b0);
        idle(3);

        // Ring frozen across pipe_stall
        step(1'b1, FADD_SUB_unit, 1'b0);
        step(1'b1, ALU_unit, 1'b1);
        repeat (2) step(1'b0, DEFAULT_unit, 1'b1);
        idle(4);

        // Reset mid-stream with three pending reservations
        step(1'b1, FMUL_unit, 1'b0);
        step(1'b1, R4_unit, 1'b0);
        step(1'b1, MUL_unit, 1'b0);
        mid_reset();
        step(1'b1, ALU_unit, 1'b0);
        idle(7);

        // Randomised traffic
        repeat (600) begin
            if ($urandom_range(0, 3) == 0) pend = pend | 3'($urandom_range(0, 7));
            step(($urandom_range(0, 2) != 0),
                 priority_t'(4'($urandom_range(0, 9))),
                 ($urandom_range(0, 7) == 0));
        end
        idle(15);

        @(negedge clk); #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
